// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and bubble insertion.
// Optional HAZARD_CNT_EN adds a saturating count of stall-induced bubbles.
module id_ex_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      id_ctrl,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [WIDTH-1:0] id_pc4,
  input  logic             flush,
  output logic [10:0]      ex_ctrl,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [WIDTH-1:0] ex_rd1,
  output logic [WIDTH-1:0] ex_rd2,
  output logic [WIDTH-1:0] ex_imm,
  output logic [WIDTH-1:0] ex_pc4,
  output logic             ex_valid,
`ifdef HAZARD_CNT_EN
  output logic [15:0]      bubble_count,
`endif
  output logic             stall
);

  localparam int unsigned ALU_SRC_BIT   = 7;
  localparam int unsigned MEM_READ_BIT  = 4;
  localparam int unsigned MEM_WRITE_BIT = 3;

  logic [10:0]      ctrl_q, ctrl_d;
  logic [4:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             rt_use, hazard, capture;

  always_comb begin
    rt_use  = ~id_ctrl[ALU_SRC_BIT] | id_ctrl[MEM_WRITE_BIT];
    hazard  = id_valid & valid_q & ctrl_q[MEM_READ_BIT] & (rt_q != 5'd0) &
              ((rt_q == id_rs) | ((rt_q == id_rt) & rt_use));
    stall   = hazard & ~flush;
    capture = id_valid & ~flush & ~stall;

    ctrl_d  = '0;
    rs_d    = '0;
    rt_d    = '0;
    rd_d    = '0;
    rd1_d   = '0;
    rd2_d   = '0;
    imm_d   = '0;
    pc4_d   = '0;
    valid_d = 1'b0;
    if (capture) begin
      ctrl_d  = id_ctrl;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = id_imm;
      pc4_d   = id_pc4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef HAZARD_CNT_EN
  logic [15:0] bubble_count_q, bubble_count_d;

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (stall && bubble_count_q != '1) begin
      bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
`endif

  assign ex_ctrl  = ctrl_q;
  assign ex_rs    = rs_q;
  assign ex_rt    = rt_q;
  assign ex_rd    = rd_q;
  assign ex_rd1   = rd1_q;
  assign ex_rd2   = rd2_q;
  assign ex_imm   = imm_q;
  assign ex_pc4   = pc4_q;
  assign ex_valid = valid_q;

endmodule
